// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO for fetched {pc, instr} entries; head is read directly from storage.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (!do_push && do_pop) begin
        count <= count - (PTR_W + 1)'(1);
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Fetch front end: owns the fetch PC, issues credit-limited imem reads and queues words for decode.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/killed/stall counters.
module fetch_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DATA_W = fetch_pkg::DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   pause,
  input  logic                   redirect_valid,
  input  logic [DATA_W-1:0]      redirect_pc,
  output logic                   imem_req,
  output logic [DATA_W-1:0]      imem_addr,
  input  logic [DATA_W-1:0]      imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [DATA_W-1:0]      instruction,
  output logic [DATA_W-1:0]      instr_pc,
  output logic [DATA_W-1:0]      pc_plus4,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_killed,
  output logic [31:0]            perf_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [DATA_W-1:0] WORD_MASK = ~DATA_W'(3);

  fetch_state_e        state;
  logic [DATA_W-1:0]   fetch_pc;
  logic [DATA_W-1:0]   inflight_pc;
  logic [DATA_W-1:0]   redirect_target;
  logic                inflight;
  logic                head_seen;
  logic                has_credit;
  logic                issue;
  logic                push;
  logic                pop;
  logic                kill;
  logic                fifo_empty;
  logic [2*DATA_W-1:0] head;

  assign redirect_target = redirect_pc & WORD_MASK;

  // Outstanding request counts against capacity so a same-cycle push and pop can never overflow.
  assign has_credit = (fifo_count + CNT_W'(inflight)) < DEPTH_CNT;
  assign issue      = (state == S_FETCH) && !pause && has_credit && !redirect_valid;
  assign push       = inflight && !redirect_valid;
  assign kill       = inflight && redirect_valid;
  assign pop        = instr_valid && instr_ready && !redirect_valid;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state       <= S_INIT;
      fetch_pc    <= RESET_PC & WORD_MASK;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      // Restart fetching straight away so the target is requested in the very next cycle.
      state    <= pause ? S_STALL : S_FETCH;
      fetch_pc <= redirect_target;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + DATA_W'(PC_INC);
      end
      unique case (state)
        S_INIT:  state <= S_FETCH;
        S_FETCH: if (pause || !has_credit) state <= S_STALL;
        S_STALL: if (!pause && has_credit) state <= S_FETCH;
        default: state <= S_INIT;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_fifo (
    .clk       (CLOCK_50),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (push),
    .push_data ({inflight_pc, imem_rdata}),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Until the first word lands the head is the all-zero reset entry; keep pc_plus4 at zero too.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      head_seen <= 1'b0;
    end else if (push) begin
      head_seen <= 1'b1;
    end
  end

  assign instr_valid = !fifo_empty;
  assign instr_pc    = head[2*DATA_W-1:DATA_W];
  assign instruction = head[DATA_W-1:0];
  assign pc_plus4    = head_seen ? (instr_pc + DATA_W'(PC_INC)) : '0;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_killed  <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && (perf_fetched != '1)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (kill && (perf_killed != '1)) begin
        perf_killed <= perf_killed + 32'd1;
      end
      if (instr_valid && !instr_ready && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`else
  logic unused_kill;
  assign unused_kill = kill;
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Randomised bench for fetch_prefetch_buffer against a queue-based model, plus directed literal checks.
module tb_fetch_prefetch_buffer;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        pause;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [2:0]  fifo_count;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_p4;
  logic [2:0]  w_count;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_killed, perf_stall;
  logic [31:0] w_pf, w_pk, w_ps;
`endif

  fetch_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .pause          (pause),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .pc_plus4       (pc_plus4),
    .fifo_count     (fifo_count)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_killed    (perf_killed),
    .perf_stall     (perf_stall)
`endif
  );

  fetch_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_wrap (
    .CLOCK_50       (clk),
    .reset          (reset),
    .pause          (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_rdata     (w_rdata),
    .instr_valid    (w_valid),
    .instr_ready    (1'b1),
    .instruction    (w_instr),
    .instr_pc       (w_pc),
    .pc_plus4       (w_p4),
    .fifo_count     (w_count)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (w_pf),
    .perf_killed    (w_pk),
    .perf_stall     (w_ps)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  // Synchronous memories: data for a request appears one cycle later, garbage otherwise.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    w_rdata    <= w_req ? w_addr : 32'hDEAD_BEEF;
  end

  int tests = 0;
  int fails = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of buffered words, one outstanding request, a fetch PC and a mode.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  bit          known   = 1'b0;
  bit          infl    = 1'b0;
  bit          hd_zero = 1'b1;
  int          mode    = 0;  // 0 init, 1 fetching, 2 stalled
  logic [31:0] fpc     = '0;
  logic [31:0] ipc     = '0;
  int unsigned m_fetched = 0, m_killed = 0, m_stall = 0;

  task automatic check_cycle();
    bit cok;
    bit ereq;
    bit do_pop;
    cok  = (q.size() + int'(infl)) < DEPTH;
    ereq = (mode == 1) && !pause && cok && !redirect_valid;
    if (known) begin
      cmp("imem_req", {31'b0, imem_req}, {31'b0, ereq});
      if (ereq) cmp("imem_addr", imem_addr, fpc);
      cmp("instr_valid", {31'b0, instr_valid}, {31'b0, q.size() != 0});
      cmp("fifo_count", {29'b0, fifo_count}, q.size());
      if (q.size() != 0) begin
        cmp("instr_pc", instr_pc, q[0].pc);
        cmp("instruction", instruction, q[0].ins);
        cmp("pc_plus4", pc_plus4, q[0].pc + 32'd4);
      end else if (hd_zero) begin
        cmp("instr_pc_rst", instr_pc, 32'h0);
        cmp("instruction_rst", instruction, 32'h0);
        cmp("pc_plus4_rst", pc_plus4, 32'h0);
      end
`ifdef FETCH_PERF_CNT_EN
      cmp("perf_fetched", perf_fetched, m_fetched);
      cmp("perf_killed", perf_killed, m_killed);
      cmp("perf_stall", perf_stall, m_stall);
`endif
    end
    // Advance the model across the coming rising edge.
    if (!reset) begin
      known = 1'b1; q.delete(); infl = 1'b0; hd_zero = 1'b1; mode = 0; fpc = 32'h0;
      m_fetched = 0; m_killed = 0; m_stall = 0;
    end else if (known) begin
      if (q.size() != 0 && !instr_ready) m_stall++;
      if (redirect_valid) begin
        if (infl) m_killed++;
        q.delete();
        infl = 1'b0;
        fpc  = redirect_pc & 32'hFFFF_FFFC;
        mode = pause ? 2 : 1;
      end else begin
        do_pop = (q.size() != 0) && instr_ready;
        if (do_pop) void'(q.pop_front());
        if (infl) begin
          q.push_back('{ipc, mem_word(ipc)});
          m_fetched++;
          hd_zero = 1'b0;
        end
        infl = ereq;
        if (ereq) begin
          ipc = fpc;
          fpc = fpc + 32'd4;
        end
        case (mode)
          0: mode = 1;
          1: if (pause || !cok) mode = 2;
          default: if (!pause && cok) mode = 1;
        endcase
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      check_cycle();
    end
  end

  // Wrap instance: first three words after reset must be FFFF_FFF8, FFFF_FFFC, 0.
  initial begin
    int n;
    logic [31:0] pcs[3];
    logic [31:0] p4s[3];
    logic [31:0] ins[3];
    logic [31:0] exp_pc[3];
    logic [31:0] exp_p4[3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    exp_p4[0] = 32'hFFFF_FFFC; exp_p4[1] = 32'h0000_0000; exp_p4[2] = 32'h0000_0004;
    n = 0;
    @(posedge reset);
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk);
      #3;
      if (w_valid) begin
        pcs[n] = w_pc; p4s[n] = w_p4; ins[n] = w_instr;
        n++;
      end
    end
    cmp("wrap_words_seen", n, 3);
    for (int k = 0; k < n; k++) begin
      cmp("wrap_instr_pc", pcs[k], exp_pc[k]);
      cmp("wrap_pc_plus4", p4s[k], exp_p4[k]);
      cmp("wrap_instruction", ins[k], exp_pc[k]);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int first_req, first_val, idx;
    logic [31:0] v_pc, v_p4;
    bit prev_req, found;

    reset = 1'b0; pause = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    repeat (3) tick();

    // Reset release latency.
    reset = 1'b1;
    first_req = -1; first_val = -1; v_pc = 'x; v_p4 = 'x;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (imem_req && first_req < 0) first_req = i;
      if (instr_valid && first_val < 0) begin
        first_val = i; v_pc = instr_pc; v_p4 = pc_plus4;
      end
      tick();
    end
    cmp("first_req_cycle", first_req, 1);
    cmp("first_valid_cycle", first_val, 3);
    cmp("first_instr_pc", v_pc, 32'h0);
    cmp("first_pc_plus4", v_p4, 32'h4);

    // Back-pressure fills the FIFO and stops requests.
    instr_ready = 1'b0;
    repeat (10) tick();
    cmp("full_count", {29'b0, fifo_count}, 32'd4);
    cmp("full_no_req", {31'b0, imem_req}, 32'd0);
    instr_ready = 1'b1;
    repeat (12) tick();

    // Redirect with three buffered words and one request in flight.
    instr_ready = 1'b0;
    prev_req = imem_req;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (fifo_count == 3'd3 && prev_req) found = 1'b1;
      else prev_req = imem_req;
    end
    cmp("redirect_setup", {31'b0, found}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    cmp("redirect_flush_count", {29'b0, fifo_count}, 32'd0);
    idx = 1;
    while (!instr_valid && idx < 10) begin
      tick();
      idx++;
    end
    cmp("redirect_latency", idx, 3);
    cmp("redirect_first_pc", instr_pc, 32'h0000_0100);
    repeat (4) tick();

    // Pause drains the FIFO.
    pause = 1'b1;
    repeat (5) tick();
    cmp("pause_drained", {29'b0, fifo_count}, 32'd0);
    pause = 1'b0;
    repeat (10) tick();

    // Randomised traffic with occasional redirects, pauses and resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      instr_ready    = ($urandom_range(0, 9) < 7);
      pause          = ($urandom_range(0, 19) == 0) ? ~pause : pause;
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      reset          = ($urandom_range(0, 599) != 0);
    end
    tick();
    reset = 1'b1; pause = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
